// File: rtl/ysyx_22040632_RISCV_pkg.sv
// Shared types and constants for the ysyx_22040632 core.
// Fetch-stage state, reset vector and fetch packet layout.
package ysyx_22040632_RISCV_pkg;

  localparam int XLEN = 64;

  localparam logic [XLEN-1:0] IFU_RESET_PC =
    64'h0000_0000_8000_0000;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    IFU_IDLE,
    IFU_REQ,
    IFU_WAIT,
    IFU_KILL_REQ,
    IFU_KILL_WAIT
  } ifu_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic            fault;
  } fetch_pkt_t;

endpackage

// File: rtl/ysyx_22040632_ifu_outbuf.sv
// One-entry valid/ready output register of the fetch stage.
// Flush drops the held entry; data is kept but marked invalid.
module ysyx_22040632_ifu_outbuf
  import ysyx_22040632_RISCV_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       in_valid,
  input  fetch_pkt_t in_pkt,
  output logic       in_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output fetch_pkt_t out_pkt
);

  // Space next cycle: empty now, or the entry drains this cycle.
  assign in_ready = !out_valid || out_ready;

  // Entry register: flush wins, then load, then drain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_pkt   <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (in_valid) begin
      out_valid <= 1'b1;
      out_pkt   <= in_pkt;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ysyx_22040632_ifu.sv
// Instruction fetch stage: owns the PC, one outstanding
// memory request, one-entry output register, redirect flush.
module ysyx_22040632_ifu
  import ysyx_22040632_RISCV_pkg::*;
#(
  parameter int              PC_W     = 64,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(IFU_RESET_PC)
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [PC_W-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            imem_rsp_err,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst_data,
  output logic [PC_W-1:0] inst_pc,
  output logic            inst_fault
);

  ifu_state_e      state, state_n;
  logic [PC_W-1:0] pc, pc_n;
  logic [PC_W-1:0] addr_n;
  logic [PC_W-1:0] tgt_pc;
  logic            load;
  logic            space;
  fetch_pkt_t      in_pkt;
  fetch_pkt_t      out_pkt;

  // Redirect targets are word aligned by clearing the low bits.
  assign tgt_pc = redirect_pc & ~PC_W'(3);

  assign imem_req_valid = (state == IFU_REQ) ||
                          (state == IFU_KILL_REQ);

  // Faulting fetches hand a NOP downstream.
  always_comb begin
    in_pkt       = '0;
    in_pkt.pc    = XLEN'(pc);
    in_pkt.instr = imem_rsp_err ? NOP_INSTR : imem_rsp_data;
    in_pkt.fault = imem_rsp_err;
  end

  // Next state, next PC and request address.
  always_comb begin
    state_n = state;
    pc_n    = pc;
    addr_n  = imem_req_addr;
    load    = 1'b0;
    unique case (state)
      IFU_IDLE: begin
        if (redirect_valid) begin
          pc_n = tgt_pc;
        end else if (space) begin
          state_n = IFU_REQ;
          addr_n  = pc;
        end
      end
      IFU_REQ: begin
        if (redirect_valid) begin
          pc_n    = tgt_pc;
          state_n = imem_req_ready ? IFU_KILL_WAIT
                                   : IFU_KILL_REQ;
        end else if (imem_req_ready) begin
          state_n = IFU_WAIT;
        end
      end
      IFU_WAIT: begin
        if (redirect_valid) begin
          pc_n    = tgt_pc;
          state_n = imem_rsp_valid ? IFU_IDLE
                                   : IFU_KILL_WAIT;
        end else if (imem_rsp_valid) begin
          load    = 1'b1;
          pc_n    = pc + PC_W'(4);
          state_n = IFU_IDLE;
        end
      end
      IFU_KILL_REQ: begin
        if (redirect_valid) pc_n = tgt_pc;
        if (imem_req_ready) state_n = IFU_KILL_WAIT;
      end
      IFU_KILL_WAIT: begin
        if (redirect_valid) pc_n = tgt_pc;
        if (imem_rsp_valid) state_n = IFU_IDLE;
      end
      default: state_n = IFU_IDLE;
    endcase
  end

  // FSM, PC and request address registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IFU_IDLE;
      pc            <= RESET_PC;
      imem_req_addr <= '0;
    end else begin
      state         <= state_n;
      pc            <= pc_n;
      imem_req_addr <= addr_n;
    end
  end

  ysyx_22040632_ifu_outbuf u_outbuf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .in_valid  (load),
    .in_pkt    (in_pkt),
    .in_ready  (space),
    .out_valid (inst_valid),
    .out_ready (inst_ready),
    .out_pkt   (out_pkt)
  );

  assign inst_pc    = out_pkt.pc[PC_W-1:0];
  assign inst_data  = out_pkt.instr;
  assign inst_fault = out_pkt.fault;

  // A response is only legal while one is expected.
  rsp_in_window: assert property (
    @(posedge clk) disable iff (!rst_n)
    imem_rsp_valid |->
      (state == IFU_WAIT || state == IFU_KILL_WAIT)
  );

endmodule
